// File: rtl/updn_sweep_ctrl.sv
// Triangle-sweep sequencer for an up/down counter: load lo, count up to hi, back down to lo, N times.
// Optional abort input is compiled in when SWEEP_ABORT_EN is defined.
module updn_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] ctr_count,
    output logic [WIDTH-1:0] ctr_data,
    output logic             ctr_load_n,
    output logic             ctr_cen,
    output logic             ctr_up_dn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] sweep_cnt
`ifdef SWEEP_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] sweep_inc;
    logic             accept;
    logic             sweep_end;
    logic             last_sweep;
    logic             abort_hit;

    // A repeat count of zero still runs one sweep.
    function automatic logic [REP_W-1:0] eff_reps(input logic [REP_W-1:0] r);
        return (r == '0) ? {{(REP_W-1){1'b0}}, 1'b1} : r;
    endfunction

    assign accept     = (state == S_IDLE) && start;
    assign sweep_inc  = sweep_cnt + {{(REP_W-1){1'b0}}, 1'b1};
    assign last_sweep = (sweep_inc == eff_reps(reps_q));
    assign ctr_data   = lo_q;

`ifdef SWEEP_ABORT_EN
    assign abort_hit = abort && ((state == S_LOAD) || (state == S_UP) || (state == S_DOWN));
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter is held (cen=0) on the turnaround value for one cycle so it never steps past hi or lo.
    always_comb begin
        state_nxt  = state;
        ctr_load_n = 1'b1;
        ctr_cen    = 1'b0;
        ctr_up_dn  = 1'b1;
        done       = 1'b0;
        busy       = (state != S_IDLE);
        sweep_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (hi <= lo) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                ctr_load_n = 1'b0;
                state_nxt  = S_UP;
            end
            S_UP: begin
                ctr_cen = (ctr_count != hi_q);
                if (ctr_count == hi_q) begin
                    state_nxt = S_DOWN;
                end
            end
            S_DOWN: begin
                ctr_up_dn = 1'b0;
                ctr_cen   = (ctr_count != lo_q);
                if (ctr_count == lo_q) begin
                    sweep_end = 1'b1;
                    state_nxt = last_sweep ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort_hit) begin
            ctr_load_n = 1'b1;
            ctr_cen    = 1'b0;
            sweep_end  = 1'b0;
            state_nxt  = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q      <= '0;
            hi_q      <= '0;
            reps_q    <= '0;
            err       <= 1'b0;
            sweep_cnt <= '0;
        end else if (accept) begin
            lo_q      <= lo;
            hi_q      <= hi;
            reps_q    <= reps;
            err       <= (hi <= lo);
            sweep_cnt <= '0;
        end else if (sweep_end) begin
            sweep_cnt <= sweep_inc;
        end
    end

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Bench for updn_sweep_ctrl driving a behavioural DW03-style up/down counter.
// Build with SWEEP_ABORT_EN defined to include the abort scenario.
module tb_updn_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] lo_v = 4'd0;
    logic [3:0] hi_v = 4'd0;
    logic [3:0] reps_v = 4'd0;
    logic [3:0] cnt;
    logic [3:0] ctr_data;
    logic       ctr_load_n;
    logic       ctr_cen;
    logic       ctr_up_dn;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweep_cnt;
`ifdef SWEEP_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    updn_sweep_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lo         (lo_v),
        .hi         (hi_v),
        .reps       (reps_v),
        .ctr_count  (cnt),
        .ctr_data   (ctr_data),
        .ctr_load_n (ctr_load_n),
        .ctr_cen    (ctr_cen),
        .ctr_up_dn  (ctr_up_dn),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_cnt  (sweep_cnt)
`ifdef SWEEP_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    // Counter: load active-low and dominant, cen active-high, up_dn=1 counts up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 4'd0;
        else if (!ctr_load_n) cnt <= ctr_data;
        else if (ctr_cen) cnt <= ctr_up_dn ? cnt + 4'd1 : cnt - 4'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: on an accepted start the whole run is expanded into a per-cycle trace.
    typedef struct {
        bit busy;
        bit done;
        bit load_n;
        bit cen;
        bit up;
        bit dir_chk;
        bit cnt_chk;
        int cnt;
        int sweep;
        bit err;
    } rec_t;

    rec_t q[$];
    bit   m_idle = 1'b1;
    int   m_sweep = 0;
    bit   m_err = 1'b0;
    int   m_data = 0;

    function automatic rec_t mk(bit b, bit d, bit ld, bit ce, bit up, bit dc, bit cc, int c, int s, bit e);
        rec_t r;
        r.busy = b; r.done = d; r.load_n = ld; r.cen = ce; r.up = up;
        r.dir_chk = dc; r.cnt_chk = cc; r.cnt = c; r.sweep = s; r.err = e;
        return r;
    endfunction

    task automatic gen(input int l, input int h, input int r);
        int re;
        re = (r == 0) ? 1 : r;
        if (h <= l) begin
            q.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 1));
        end else begin
            q.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            for (int k = 0; k < re; k++) begin
                for (int v = l; v <= h; v++) q.push_back(mk(1, 0, 1, v != h, 1, 1, 1, v, k, 0));
                for (int v = h; v >= l; v--) q.push_back(mk(1, 0, 1, v != l, 0, 1, 1, v, k, 0));
            end
            q.push_back(mk(1, 1, 1, 0, 1, 0, 1, l, re, 0));
        end
    endtask

    always @(posedge clk) begin
        if (rst && m_idle && start && q.size() == 0) begin
            m_data = int'(lo_v);
            gen(int'(lo_v), int'(hi_v), int'(reps_v));
        end
    end

    always @(negedge rst) begin
        q.delete();
        m_idle = 1'b1;
        m_sweep = 0;
        m_err = 1'b0;
        m_data = 0;
    end

    always @(negedge clk) begin
        rec_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
`ifdef SWEEP_ABORT_EN
            if (abort && !e.done) begin
                e.load_n = 1'b1;
                e.cen = 1'b0;
                q.delete();
                q.push_back(mk(1, 1, 1, 0, 1, 0, e.cnt_chk, e.cnt, e.sweep, e.err));
            end
`endif
            m_idle = 1'b0;
            m_sweep = e.sweep;
            m_err = e.err;
        end else begin
            e = mk(0, 0, 1, 0, 1, 0, 0, 0, m_sweep, m_err);
            m_idle = 1'b1;
        end
        chk("m_busy", busy, e.busy);
        chk("m_done", done, e.done);
        chk("m_load_n", ctr_load_n, e.load_n);
        chk("m_cen", ctr_cen, e.cen);
        chk("m_sweep_cnt", sweep_cnt, e.sweep);
        chk("m_err", err, e.err);
        chk("m_data", ctr_data, m_data);
        if (e.cnt_chk) chk("m_count", cnt, e.cnt);
        if (e.dir_chk) chk("m_up_dn", ctr_up_dn, e.up);
    end

    int  log_cnt[0:255];
    bit  log_up[0:255];

    // Cycle 0 is the cycle in which start is high; the run is logged until busy falls.
    task automatic run(input logic [3:0] l, input logic [3:0] h, input logic [3:0] r, input int limit,
                       output int nbusy, output int done_at, output int ndone, output int nload);
        int  cyc;
        bit  ended;
        nbusy = 0; done_at = -1; ndone = 0; nload = 0; ended = 1'b0;
        @(posedge clk); #1;
        lo_v = l; hi_v = h; reps_v = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            log_cnt[cyc] = int'(cnt);
            log_up[cyc] = ctr_up_dn;
            if (busy) nbusy++;
            if (done) begin ndone++; done_at = cyc; end
            if (!ctr_load_n) nload++;
            if (!busy && nbusy > 0) begin ended = 1'b1; break; end
        end
        chk("run_completed", ended, 1);
    endtask

    initial begin
        int nb, da, nd, nl, nw, nt;
        bit found, seen_done;
        int exp1[6];
        exp1 = '{1, 2, 3, 3, 2, 1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_load_n", ctr_load_n, 1);
        chk("rst_cen", ctr_cen, 0);
        chk("rst_up_dn", ctr_up_dn, 1);
        chk("rst_data", ctr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sweep", sweep_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic sweep lo=1 hi=3 reps=1.
        run(4'd1, 4'd3, 4'd1, 40, nb, da, nd, nl);
        for (int i = 0; i < 6; i++) chk("t1_count", log_cnt[i + 2], exp1[i]);
        chk("t1_busy_cycles", nb, 8);
        chk("t1_done_cycle", da, 8);
        chk("t1_done_pulses", nd, 1);
        chk("t1_sweep_cnt", sweep_cnt, 1);

        // Full range lo=0 hi=15 reps=3.
        run(4'd0, 4'd15, 4'd3, 200, nb, da, nd, nl);
        nw = 0; nt = 0;
        for (int c = 2; c < nb; c++) if (log_up[c] && log_cnt[c] == 15) nt++;
        for (int c = 3; c <= nb; c++) if (log_cnt[c] - log_cnt[c - 1] > 1 || log_cnt[c - 1] - log_cnt[c] > 1) nw++;
        chk("t2_busy_cycles", nb, 98);
        chk("t2_sweep_cnt", sweep_cnt, 3);
        chk("t2_tercnt_up", nt, 3);
        chk("t2_no_wrap", nw, 0);

        // hi==lo is an error: no load, one busy cycle, done right after start.
        run(4'd5, 4'd5, 4'd1, 20, nb, da, nd, nl);
        chk("t3_busy_cycles", nb, 1);
        chk("t3_done_cycle", da, 1);
        chk("t3_load_count", nl, 0);
        chk("t3_err", err, 1);
        run(4'd2, 4'd4, 4'd1, 40, nb, da, nd, nl);
        chk("t3b_err", err, 0);
        chk("t3b_busy_cycles", nb, 8);
        chk("t3b_done_pulses", nd, 1);
        chk("t3b_sweep_cnt", sweep_cnt, 1);

        // start held high during a run with lo/hi scrambled mid-run.
        @(posedge clk); #1;
        lo_v = 4'd0; hi_v = 4'd2; reps_v = 4'd2; start = 1'b1;
        nb = 0; nd = 0; seen_done = 1'b0; found = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (seen_done) start = 1'b0;
            lo_v = 4'((c * 5) % 16);
            hi_v = 4'((c * 3) % 16);
            @(negedge clk);
            if (busy) begin nb++; chk("t4_data", ctr_data, 0); end
            if (done) begin nd++; seen_done = 1'b1; end
            if (!busy && nb > 0) begin found = 1'b1; break; end
        end
        start = 1'b0;
        chk("t4_completed", found, 1);
        chk("t4_busy_cycles", nb, 14);
        chk("t4_done_pulses", nd, 1);
        chk("t4_sweep_cnt", sweep_cnt, 2);

        // Asynchronous reset in the middle of an up-count.
        @(posedge clk); #1;
        lo_v = 4'd4; hi_v = 4'd12; reps_v = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy && ctr_up_dn && cnt == 4'd7) begin found = 1'b1; break; end
        end
        chk("t5_reached_7", found, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_load_n", ctr_load_n, 1);
        chk("t5_cen", ctr_cen, 0);
        chk("t5_up_dn", ctr_up_dn, 1);
        chk("t5_data", ctr_data, 0);
        chk("t5_sweep", sweep_cnt, 0);
        chk("t5_count", cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_count", cnt, 0);

`ifdef SWEEP_ABORT_EN
        // Abort in the down leg of sweep 2.
        @(posedge clk); #1;
        lo_v = 4'd2; hi_v = 4'd9; reps_v = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (busy && sweep_cnt == 4'd1 && !ctr_up_dn && cnt == 4'd7) begin found = 1'b1; break; end
        end
        chk("t6_reached_7", found, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("t6_abort_count", cnt, 6);
        chk("t6_abort_cen", ctr_cen, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_hold_count", cnt, 6);
        chk("t6_sweep_cnt", sweep_cnt, 1);
        @(negedge clk);
        chk("t6_idle", busy, 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
